// File: rtl/nmi_apb_arbiter.sv
// Round-robin arbiter sharing one native-memory (valid/ready) port among NUM_MASTERS requesters.
// The winning request is registered and held for the whole downstream transaction; a hung slave is aborted by a timeout.
module nmi_apb_arbiter #(
    parameter int          NUM_MASTERS    = 2,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic [NUM_MASTERS-1:0]         m_valid_i,
    input  logic [NUM_MASTERS*32-1:0]      m_addr_i,
    input  logic [NUM_MASTERS*32-1:0]      m_wdata_i,
    input  logic [NUM_MASTERS*4-1:0]       m_wstrb_i,
    output logic [NUM_MASTERS-1:0]         m_ready_o,
    output logic [31:0]                    m_rdata_o,
    output logic                           s_valid_o,
    output logic [31:0]                    s_addr_o,
    output logic [31:0]                    s_wdata_o,
    output logic [3:0]                     s_wstrb_o,
    input  logic [31:0]                    s_rdata_i,
    input  logic                           s_ready_i,
    output logic [$clog2(NUM_MASTERS)-1:0] grant_o,
    output logic                           timeout_o
);

    localparam int              GW        = $clog2(NUM_MASTERS);
    localparam int              CW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit              TO_EN     = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0]   CNT_LAST  = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [GW-1:0]   GRANT_RST = GW'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic          s_valid_q, s_valid_d;
    logic [31:0]   s_addr_q, s_addr_d;
    logic [31:0]   s_wdata_q, s_wdata_d;
    logic [3:0]    s_wstrb_q, s_wstrb_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [31:0]   addr_arr  [NUM_MASTERS];
    logic [31:0]   wdata_arr [NUM_MASTERS];
    logic [3:0]    wstrb_arr [NUM_MASTERS];

    logic          pick_found;
    logic [GW-1:0] pick_idx;
    logic [GW-1:0] cand_idx;
    logic          busy_live;
    logic          accept;
    logic          abort;

    for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_split
        assign addr_arr[k]  = m_addr_i[32*k +: 32];
        assign wdata_arr[k] = m_wdata_i[32*k +: 32];
        assign wstrb_arr[k] = m_wstrb_i[4*k +: 4];
    end

    // Search starts just after the last grant, so the previous winner has lowest priority.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = grant_q;
        cand_idx   = grant_q;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand_idx = GW'((int'(grant_q) + i) % NUM_MASTERS);
            if (!pick_found && m_valid_i[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Completion is suppressed while reset is asserted so an aborted transaction never pulses m_ready_o.
    always_comb begin
        busy_live = (state_q == ST_BUSY) && rst_n_i;
        accept    = busy_live && s_ready_i;
        abort     = busy_live && !s_ready_i && TO_EN && (cnt_q == CNT_LAST);
    end

    always_comb begin
        for (int k = 0; k < NUM_MASTERS; k++) begin
            m_ready_o[k] = (accept || abort) && (grant_q == GW'(k));
        end
        if (accept) begin
            m_rdata_o = s_rdata_i;
        end else if (abort) begin
            m_rdata_o = TIMEOUT_RDATA;
        end else begin
            m_rdata_o = '0;
        end
        timeout_o = abort;
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        s_valid_d = s_valid_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        s_wstrb_d = s_wstrb_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d   = ST_BUSY;
                    grant_d   = pick_idx;
                    s_valid_d = 1'b1;
                    s_addr_d  = addr_arr[pick_idx];
                    s_wdata_d = wdata_arr[pick_idx];
                    s_wstrb_d = wstrb_arr[pick_idx];
                    cnt_d     = '0;
                end
            end
            ST_BUSY: begin
                if (accept || abort) begin
                    state_d   = ST_DONE;
                    s_valid_d = 1'b0;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // One dead cycle lets the finished master withdraw its valid before the next arbitration.
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            grant_q   <= GRANT_RST;
            s_valid_q <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_wstrb_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            s_valid_q <= s_valid_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            s_wstrb_q <= s_wstrb_d;
            cnt_q     <= cnt_d;
        end
    end

    assign s_valid_o = s_valid_q;
    assign s_addr_o  = s_addr_q;
    assign s_wdata_o = s_wdata_q;
    assign s_wstrb_o = s_wstrb_q;
    assign grant_o   = grant_q;

endmodule

// File: tb/tb_nmi_apb_arbiter.sv
// Bench for nmi_apb_arbiter: transaction-level model compared every cycle, plus directed scenarios with literal expectations.
// Handshake: a master holds m_valid_i until it sees its m_ready_o bit; the slave raises s_ready_i for one cycle per request.
module tb_nmi_apb_arbiter;

    localparam int          N     = 2;
    localparam int          GW    = $clog2(N);
    localparam int          T     = 8;
    localparam logic [31:0] TO_RD = 32'hDEAD_BEEF;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      m_valid_i;
    logic [N*32-1:0]   m_addr_i;
    logic [N*32-1:0]   m_wdata_i;
    logic [N*4-1:0]    m_wstrb_i;
    logic [N-1:0]      m_ready_o;
    logic [31:0]       m_rdata_o;
    logic              s_valid_o;
    logic [31:0]       s_addr_o;
    logic [31:0]       s_wdata_o;
    logic [3:0]        s_wstrb_o;
    logic [31:0]       s_rdata_i;
    logic              s_ready_i;
    logic [GW-1:0]     grant_o;
    logic              timeout_o;

    logic [31:0] req_addr  [N];
    logic [31:0] req_wdata [N];
    logic [3:0]  req_wstrb [N];

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign m_addr_i[32*g +: 32] = req_addr[g];
        assign m_wdata_i[32*g +: 32] = req_wdata[g];
        assign m_wstrb_i[4*g +: 4]  = req_wstrb[g];
    end

    nmi_apb_arbiter #(
        .NUM_MASTERS   (N),
        .TIMEOUT_CYCLES(T),
        .TIMEOUT_RDATA (TO_RD)
    ) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .m_valid_i(m_valid_i),
        .m_addr_i (m_addr_i),
        .m_wdata_i(m_wdata_i),
        .m_wstrb_i(m_wstrb_i),
        .m_ready_o(m_ready_o),
        .m_rdata_o(m_rdata_o),
        .s_valid_o(s_valid_o),
        .s_addr_o (s_addr_o),
        .s_wdata_o(s_wdata_o),
        .s_wstrb_o(s_wstrb_o),
        .s_rdata_i(s_rdata_i),
        .s_ready_i(s_ready_i),
        .grant_o  (grant_o),
        .timeout_o(timeout_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- counters and monitor records ----------------
    int          total = 0;
    int          bad   = 0;
    bit          chk_en = 1'b0;
    int          cyc = 0;
    int          vcyc = 0;
    int          to_at = 0;
    int          to_cnt = 0;
    int          done_q [$];
    int          stamp_q [$];
    logic [31:0] last_rdata, last_wdata, last_addr;
    logic [3:0]  last_wstrb;
    logic [N-1:0] seen_ready = '0;

    // slave / master behaviour knobs
    int          slave_lat = 1;
    int          busy_cnt = 0;
    logic [31:0] rdata_val = '0;
    logic [N-1:0] cont = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          mdl_phase = 0;   // 0 = waiting for requests, 1 = transaction open, 2 = cool-down
    int          mdl_grant = N - 1;
    int          mdl_age = 0;     // cycles the open transaction has already spent unanswered
    logic [31:0] mdl_addr = '0;
    logic [31:0] mdl_wdata = '0;
    logic [3:0]  mdl_wstrb = '0;

    function automatic int rr_pick(input int last, input logic [N-1:0] v);
        int c;
        int res;
        res = -1;
        for (int i = 1; i <= N; i++) begin
            c = (last + i) % N;
            if (res < 0 && v[c[GW-1:0]]) res = c;
        end
        return res;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            mdl_phase <= 0;
            mdl_grant <= N - 1;
            mdl_age   <= 0;
            mdl_addr  <= '0;
            mdl_wdata <= '0;
            mdl_wstrb <= '0;
        end else if (mdl_phase == 0) begin
            if (rr_pick(mdl_grant, m_valid_i) >= 0) begin
                mdl_phase <= 1;
                mdl_age   <= 0;
                mdl_grant <= rr_pick(mdl_grant, m_valid_i);
                mdl_addr  <= req_addr[rr_pick(mdl_grant, m_valid_i)];
                mdl_wdata <= req_wdata[rr_pick(mdl_grant, m_valid_i)];
                mdl_wstrb <= req_wstrb[rr_pick(mdl_grant, m_valid_i)];
            end
        end else if (mdl_phase == 1) begin
            if (s_ready_i || mdl_age == T - 1) begin
                mdl_phase <= 2;
                mdl_age   <= 0;
            end else begin
                mdl_age <= mdl_age + 1;
            end
        end else begin
            mdl_phase <= 0;
        end
    end

    // ---------------- scoreboard: one compare per cycle on the falling edge ----------------
    task automatic compare_cycle();
        logic         live, acc, abrt;
        logic [N-1:0] er;
        logic [31:0]  erd;
        int           idx;
        live = (mdl_phase == 1) && rst_n;
        acc  = live && s_ready_i;
        abrt = live && !s_ready_i && (mdl_age == T - 1);
        er   = '0;
        if (acc || abrt) er[mdl_grant[GW-1:0]] = 1'b1;
        erd  = acc ? s_rdata_i : (abrt ? TO_RD : 32'h0);
        check("cyc_m_ready", m_ready_o, er);
        check("cyc_m_rdata", m_rdata_o, erd);
        check("cyc_timeout", timeout_o, abrt);
        check("cyc_s_valid", s_valid_o, mdl_phase == 1);
        check("cyc_s_addr", s_addr_o, mdl_addr);
        check("cyc_s_wdata", s_wdata_o, mdl_wdata);
        check("cyc_s_wstrb", s_wstrb_o, mdl_wstrb);
        check("cyc_grant", grant_o, mdl_grant);
        if (m_ready_o != '0) begin
            idx = 0;
            for (int k = 0; k < N; k++) if (m_ready_o[k]) idx = k;
            done_q.push_back(idx);
            stamp_q.push_back(cyc);
            last_rdata = m_rdata_o;
            last_wdata = s_wdata_o;
            last_wstrb = s_wstrb_o;
            last_addr  = s_addr_o;
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (s_valid_o) vcyc++;
        else vcyc = 0;
        if (timeout_o) begin
            to_cnt++;
            to_at = vcyc;
        end
        seen_ready = m_ready_o;
        if (chk_en) compare_cycle();
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (s_valid_o) busy_cnt++;
        else busy_cnt = 0;
        s_ready_i = (slave_lat != 0) && s_valid_o && (busy_cnt == slave_lat);
        s_rdata_i = s_ready_i ? rdata_val : $urandom();
        for (int k = 0; k < N; k++) begin
            if (seen_ready[k] && !cont[k]) m_valid_i[k] = 1'b0;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [GW-1:0] kk;
        kk = k[GW-1:0];
        req_addr[kk]  = a;
        req_wdata[kk] = d;
        req_wstrb[kk] = s;
        m_valid_i[kk] = 1'b1;
    endtask

    task automatic wait_done(input int n, input int budget);
        int t;
        t = 0;
        while (done_q.size() < n && t < budget) begin
            tick();
            t++;
        end
        check("wait_done_count", done_q.size(), n);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_valid_i = '0;
        ticks(2);
        rst_n = 1'b1;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int base;
        rst_n     = 1'b0;
        m_valid_i = '0;
        s_ready_i = 1'b0;
        s_rdata_i = '0;
        for (int k = 0; k < N; k++) begin
            req_addr[k]  = '0;
            req_wdata[k] = '0;
            req_wstrb[k] = '0;
        end
        ticks(3);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        @(negedge clk);
        check("reset_grant", grant_o, 1);
        check("reset_s_valid", s_valid_o, 0);
        check("reset_m_ready", m_ready_o, 0);

        // single read, slave answers on its 4th busy cycle
        slave_lat = 4;
        rdata_val = 32'h1234_5678;
        tick();
        set_req(0, 32'h0300_1000, 32'h0, 4'h0);
        @(negedge clk);
        check("t1_no_early_valid", s_valid_o, 0);
        tick();
        @(negedge clk);
        check("t1_latency_valid", s_valid_o, 1);
        check("t1_addr", s_addr_o, 32'h0300_1000);
        base = done_q.size();
        wait_done(base + 1, 20);
        check("t1_master", done_q[base], 0);
        check("t1_rdata", last_rdata, 32'h1234_5678);
        check("t1_grant", grant_o, 0);
        ticks(2);

        // simultaneous requests from reset, immediate slave
        do_reset();
        slave_lat = 1;
        rdata_val = 32'h0000_0011;
        set_req(0, 32'h0300_0100, 32'h0, 4'h0);
        set_req(1, 32'h0300_0200, 32'h0, 4'h0);
        base = done_q.size();
        wait_done(base + 2, 30);
        check("t2_first", done_q[base], 0);
        check("t2_second", done_q[base + 1], 1);
        check("t2_last_addr", last_addr, 32'h0300_0200);
        ticks(2);

        // continuous contention: both masters re-request forever
        cont = 2'b11;
        set_req(0, 32'h0300_0300, 32'h0, 4'h0);
        set_req(1, 32'h0300_0400, 32'h0, 4'h0);
        base = done_q.size();
        wait_done(base + 10, 80);
        m_valid_i = '0;
        cont = '0;
        for (int i = 0; i < 10; i++) check("t3_rotation", done_q[base + i], i % 2);
        for (int i = 1; i < 10; i++) check("t3_spacing", stamp_q[base + i] - stamp_q[base + i - 1], 3);
        ticks(3);

        // write from master 1 that drops valid and scribbles its bus after the grant
        slave_lat = 3;
        set_req(1, 32'h0300_2004, 32'hA5A5_0000, 4'hF);
        tick();
        tick();
        m_valid_i[1]  = 1'b0;
        req_addr[1]   = 32'hFFFF_FFFF;
        req_wdata[1]  = 32'h0BAD_0BAD;
        req_wstrb[1]  = 4'h1;
        base = done_q.size();
        wait_done(base + 1, 20);
        check("t4_master", done_q[base], 1);
        check("t4_wdata", last_wdata, 32'hA5A5_0000);
        check("t4_wstrb", last_wstrb, 4'hF);
        check("t4_addr", last_addr, 32'h0300_2004);
        ticks(2);

        // timeout: slave never answers
        slave_lat = 0;
        set_req(0, 32'h0300_3000, 32'h0, 4'h0);
        base = done_q.size();
        wait_done(base + 1, 30);
        check("t5_master", done_q[base], 0);
        check("t5_rdata", last_rdata, TO_RD);
        check("t5_busy_cycle", to_at, 8);
        check("t5_to_count", to_cnt, 1);
        @(negedge clk);
        check("t5_valid_dropped", s_valid_o, 0);
        slave_lat = 2;
        rdata_val = 32'hCAFE_0001;
        tick();
        set_req(1, 32'h0300_3004, 32'h0, 4'h0);
        wait_done(base + 2, 30);
        check("t5_next_master", done_q[base + 1], 1);
        check("t5_next_rdata", last_rdata, 32'hCAFE_0001);
        check("t5_to_count_after", to_cnt, 1);
        ticks(2);

        // reset while a transaction is open
        slave_lat = 0;
        set_req(0, 32'h0300_4000, 32'h0, 4'h0);
        ticks(3);
        base = done_q.size();
        rst_n = 1'b0;
        m_valid_i = '0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_s_valid", s_valid_o, 0);
        check("t6_grant", grant_o, 1);
        check("t6_m_ready", m_ready_o, 0);
        check("t6_no_pulse", done_q.size(), base);
        slave_lat = 1;
        tick();
        set_req(1, 32'h0300_4004, 32'h0, 4'h0);
        set_req(0, 32'h0300_4008, 32'h0, 4'h0);
        wait_done(base + 2, 30);
        check("t6_first", done_q[base], 0);
        check("t6_second", done_q[base + 1], 1);
        ticks(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
